// File: rtl/idli_pkg.sv
// Shared types and constants for the idli SQI memory port.
package idli_pkg;

    typedef logic [3:0] sqi_data_t;

    typedef enum logic [2:0] {
        SQI_IDLE,
        SQI_CMD,
        SQI_ADDR,
        SQI_DUMMY,
        SQI_DATA
    } sqi_ctrl_state_t;

    localparam logic [7:0]  SQI_CMD_READ     = 8'h03;
    localparam logic [7:0]  SQI_CMD_WRITE    = 8'h02;
    localparam int unsigned SQI_CMD_NIBBLES  = 2;
    localparam int unsigned SQI_ADDR_NIBBLES = 6;
    localparam int unsigned SQI_DATA_NIBBLES = 4;

    // Command byte followed by the 24-bit byte address of a 16-bit word.
    function automatic logic [31:0] sqi_shift_word(input logic wr, input logic [15:0] addr);
        return {(wr ? SQI_CMD_WRITE : SQI_CMD_READ), 7'b0, addr, 1'b0};
    endfunction

endpackage

// File: rtl/idli_sqi_ctrl_m_if.sv
// Request and SQI pin-control bundle between the requester, idli_sqi_ctrl_m and the pads.
interface idli_sqi_ctrl_m_if;
    import idli_pkg::*;

    logic        i_req_vld;
    logic        i_req_wr;
    logic [15:0] i_req_addr;
    logic        o_req_rdy;
    logic        o_req_done;
    logic        o_sqi_cs_n;
    logic        o_sqi_oe;
    logic        o_sqi_src;
    sqi_data_t   o_sqi_data;
    logic        o_buf_wr_en;

    modport master (
        input  i_req_vld, i_req_wr, i_req_addr,
        output o_req_rdy, o_req_done, o_sqi_cs_n, o_sqi_oe, o_sqi_src, o_sqi_data, o_buf_wr_en
    );

    modport slave (
        output i_req_vld, i_req_wr, i_req_addr,
        input  o_req_rdy, o_req_done, o_sqi_cs_n, o_sqi_oe, o_sqi_src, o_sqi_data, o_buf_wr_en
    );

endinterface

// File: rtl/idli_sqi_ctrl_m.sv
// SQI word read/write sequencer: CMD, ADDR, DUMMY and DATA phases on one quad-SPI port.
// Optional back-to-back sequential-word continuation under IDLI_SQI_CTRL_BURST_EN.
module idli_sqi_ctrl_m
    import idli_pkg::*;
#(
    parameter int unsigned DUMMY_CYCLES = 2
) (
    input logic               i_sqi_gck,
    input logic               i_sqi_rst,
    idli_sqi_ctrl_m_if.master bus
);

    sqi_ctrl_state_t state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [31:0]     shift_q, shift_d;
    logic            wr_q, wr_d;
    logic            cs_n_q, cs_n_d;
    logic            oe_q, oe_d;
    logic            src_q, src_d;
    sqi_data_t       data_q, data_d;
    logic            buf_wr_en_q, buf_wr_en_d;
    logic            done_q, done_d;
    logic            last_c;
    logic            rdy_c;
    logic            accept_c;

    assign last_c = (cnt_q == 4'd0);

`ifdef IDLI_SQI_CTRL_BURST_EN
    logic [15:0] addr_q, addr_d;
    logic        burst_c;

    // Continue only with the very next word in the same direction, never across the wrap.
    assign burst_c = (state_q == SQI_DATA) && last_c && bus.i_req_vld &&
                     (bus.i_req_wr == wr_q) && (addr_q != 16'hFFFF) &&
                     (bus.i_req_addr == addr_q + 16'd1);
    assign rdy_c   = (state_q == SQI_IDLE) || burst_c;
`else
    assign rdy_c   = (state_q == SQI_IDLE);
`endif

    assign accept_c = bus.i_req_vld && rdy_c;

    always_ff @(posedge i_sqi_gck or posedge i_sqi_rst) begin
        if (i_sqi_rst) begin
            state_q     <= SQI_IDLE;
            cnt_q       <= 4'd0;
            shift_q     <= 32'd0;
            wr_q        <= 1'b0;
            cs_n_q      <= 1'b1;
            oe_q        <= 1'b0;
            src_q       <= 1'b0;
            data_q      <= '0;
            buf_wr_en_q <= 1'b0;
            done_q      <= 1'b0;
`ifdef IDLI_SQI_CTRL_BURST_EN
            addr_q      <= 16'd0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            wr_q        <= wr_d;
            cs_n_q      <= cs_n_d;
            oe_q        <= oe_d;
            src_q       <= src_d;
            data_q      <= data_d;
            buf_wr_en_q <= buf_wr_en_d;
            done_q      <= done_d;
`ifdef IDLI_SQI_CTRL_BURST_EN
            addr_q      <= addr_d;
`endif
        end
    end

    // Next state, then registered pin values decoded from the state being entered.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q - 4'd1;
        shift_d = shift_q;
        wr_d    = wr_q;
`ifdef IDLI_SQI_CTRL_BURST_EN
        addr_d  = addr_q;
`endif

        case (state_q)
            SQI_IDLE: begin
                cnt_d = cnt_q;
                if (accept_c) begin
                    state_d = SQI_CMD;
                    cnt_d   = 4'(SQI_CMD_NIBBLES - 1);
                    shift_d = sqi_shift_word(bus.i_req_wr, bus.i_req_addr);
                    wr_d    = bus.i_req_wr;
`ifdef IDLI_SQI_CTRL_BURST_EN
                    addr_d  = bus.i_req_addr;
`endif
                end
            end
            SQI_CMD: begin
                shift_d = shift_q << 4;
                if (last_c) begin
                    state_d = SQI_ADDR;
                    cnt_d   = 4'(SQI_ADDR_NIBBLES - 1);
                end
            end
            SQI_ADDR: begin
                shift_d = shift_q << 4;
                if (last_c) begin
                    if (wr_q) begin
                        state_d = SQI_DATA;
                        cnt_d   = 4'(SQI_DATA_NIBBLES - 1);
                    end else begin
                        state_d = SQI_DUMMY;
                        cnt_d   = 4'(DUMMY_CYCLES - 1);
                    end
                end
            end
            SQI_DUMMY: begin
                if (last_c) begin
                    state_d = SQI_DATA;
                    cnt_d   = 4'(SQI_DATA_NIBBLES - 1);
                end
            end
            SQI_DATA: begin
                if (last_c) begin
                    if (accept_c) begin
                        state_d = SQI_DATA;
                        cnt_d   = 4'(SQI_DATA_NIBBLES - 1);
`ifdef IDLI_SQI_CTRL_BURST_EN
                        addr_d  = bus.i_req_addr;
`endif
                    end else begin
                        state_d = SQI_IDLE;
                        cnt_d   = 4'd0;
                    end
                end
            end
            default: begin
                state_d = SQI_IDLE;
                cnt_d   = 4'd0;
            end
        endcase

        cs_n_d      = (state_d == SQI_IDLE);
        oe_d        = (state_d == SQI_CMD) || (state_d == SQI_ADDR) ||
                      ((state_d == SQI_DATA) && wr_d);
        src_d       = (state_d == SQI_DATA) && wr_d;
        data_d      = ((state_d == SQI_CMD) || (state_d == SQI_ADDR)) ? shift_d[31:28] : '0;
        // Read capture strobe leads the pin data by one cycle.
        buf_wr_en_d = !wr_d && (((state_d == SQI_DUMMY) && (cnt_d == 4'd0)) ||
                                ((state_d == SQI_DATA) && (cnt_d != 4'd0)));
        done_d      = (state_q == SQI_DATA) && last_c;
    end

    assign bus.o_req_rdy   = rdy_c;
    assign bus.o_req_done  = done_q;
    assign bus.o_sqi_cs_n  = cs_n_q;
    assign bus.o_sqi_oe    = oe_q;
    assign bus.o_sqi_src   = src_q;
    assign bus.o_sqi_data  = data_q;
`ifdef IDLI_SQI_CTRL_BURST_EN
    assign bus.o_buf_wr_en = buf_wr_en_q || (burst_c && !wr_q);
`else
    assign bus.o_buf_wr_en = buf_wr_en_q;
`endif

endmodule
